l2_cache_control: RTL and testbench

Control FSM for the unified 2-way set-associative, write-back/write-allocate L2 cache between the L1 arbiter and physical memory. It takes whole-line read/write requests from the arbiter, uses hit/dirty/LRU status from the L2 datapath, and drives datapath load/select strobes and physical-memory handshakes. It also keeps saturating hit/miss counters for performance runs.

---
 rtl/l2_cache_control.sv | 124 ++++++++++++
 tb/tb_l2_cache_control.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/l2_cache_control.sv
// rtl/l2_cache_control.sv - control FSM and saturating hit/miss counters for the 2-way write-back L2
module l2_cache_control (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        mem_resp,
    input  logic        hit0,
    input  logic        hit1,
    input  logic        lru,
    input  logic        dirty_lru,
    output logic        pmem_read,
    output logic        pmem_write,
    input  logic        pmem_resp,
    output logic        way_sel,
    output logic        load_data,
    output logic        load_tag,
    output logic        set_valid,
    output logic        set_dirty,
    output logic        clr_dirty,
    output logic        load_lru,
    output logic        lru_in,
    output logic        data_src,
    output logic        pmem_addr_sel,
    input  logic        clr_counts,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);
    typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, ALLOCATE} state_t;

    state_t state;
    logic   req;
    logic   hit;
    logic   hit_way;
    logic   hit_inc;
    logic   miss_inc;

    assign req      = mem_read | mem_write;
    assign hit      = hit0 | hit1;
    assign hit_way  = hit1 & ~hit0;
    assign hit_inc  = (state == CHECK) & req & hit;
    assign miss_inc = (state == CHECK) & req & ~hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:      if (req) state <= CHECK;
                CHECK: begin
                    if (!req || hit) state <= IDLE;
                    else if (dirty_lru) state <= WRITEBACK;
                    else state <= ALLOCATE;
                end
                WRITEBACK: if (pmem_resp) state <= ALLOCATE;
                ALLOCATE:  if (pmem_resp) state <= CHECK;
                default:   state <= IDLE;
            endcase
        end
    end

    // A clear in the same cycle as an increment wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= 16'h0000;
            miss_count <= 16'h0000;
        end else if (clr_counts) begin
            hit_count  <= 16'h0000;
            miss_count <= 16'h0000;
        end else begin
            if (hit_inc && hit_count != 16'hFFFF) hit_count <= hit_count + 16'h0001;
            if (miss_inc && miss_count != 16'hFFFF) miss_count <= miss_count + 16'h0001;
        end
    end

    always_comb begin
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        way_sel       = 1'b0;
        load_data     = 1'b0;
        load_tag      = 1'b0;
        set_valid     = 1'b0;
        set_dirty     = 1'b0;
        clr_dirty     = 1'b0;
        load_lru      = 1'b0;
        lru_in        = 1'b0;
        data_src      = 1'b0;
        pmem_addr_sel = 1'b0;
        case (state)
            CHECK: begin
                if (req && hit) begin
                    way_sel  = hit_way;
                    mem_resp = 1'b1;
                    load_lru = 1'b1;
                    lru_in   = ~hit_way;
                    if (mem_write) begin
                        load_data = 1'b1;
                        set_dirty = 1'b1;
                    end
                end else if (req) begin
                    way_sel = lru;
                end
            end
            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                way_sel       = lru;
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                way_sel   = lru;
                if (pmem_resp) begin
                    load_data = 1'b1;
                    data_src  = 1'b1;
                    load_tag  = 1'b1;
                    set_valid = 1'b1;
                    clr_dirty = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_l2_cache_control.sv
// tb/tb_l2_cache_control.sv - scoreboard bench for l2_cache_control with a one-set datapath and pmem model
module tb_l2_cache_control;
    localparam int PLAT = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic mem_read = 1'b0, mem_write = 1'b0, mem_resp;
    logic hit0, hit1, lru, dirty_lru;
    logic pmem_read, pmem_write, pmem_resp;
    logic way_sel, load_data, load_tag, set_valid, set_dirty, clr_dirty;
    logic load_lru, lru_in, data_src, pmem_addr_sel;
    logic clr_counts = 1'b0;
    logic [15:0] hit_count, miss_count;

    l2_cache_control dut (
        .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(mem_resp), .hit0(hit0), .hit1(hit1), .lru(lru), .dirty_lru(dirty_lru),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .way_sel(way_sel), .load_data(load_data), .load_tag(load_tag), .set_valid(set_valid),
        .set_dirty(set_dirty), .clr_dirty(clr_dirty), .load_lru(load_lru), .lru_in(lru_in),
        .data_src(data_src), .pmem_addr_sel(pmem_addr_sel), .clr_counts(clr_counts),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // one-set datapath model
    logic       vld [2];
    logic [7:0] tag [2];
    logic       drt [2];
    logic       lru_m;
    logic [7:0] req_tag = 8'h00;

    assign hit0      = vld[0] && tag[0] == req_tag;
    assign hit1      = vld[1] && tag[1] == req_tag;
    assign lru       = lru_m;
    assign dirty_lru = drt[lru_m];

    always @(posedge clk) begin
        if (reset_n) begin
            if (load_tag)  tag[way_sel] <= req_tag;
            if (set_valid) vld[way_sel] <= 1'b1;
            if (clr_dirty) drt[way_sel] <= 1'b0;
            if (set_dirty) drt[way_sel] <= 1'b1;
            if (load_lru)  lru_m <= lru_in;
        end
    end

    // pmem answers PLAT cycles after a request is raised
    int pcnt = 0;
    assign pmem_resp = (pmem_read | pmem_write) && pcnt == PLAT - 1;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) pcnt <= 0;
        else if (pmem_read | pmem_write) pcnt <= pmem_resp ? 0 : pcnt + 1;
        else pcnt <= 0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic way;
        logic wr;
        int   start;
        int   lat;
    } exp_t;
    exp_t exp_q[$];

    int resp_cnt = 0;
    int rd_cycles = 0, wr_cycles = 0, fills = 0, bad = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_resp) begin
                resp_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp_way", way_sel, e.way);
                    check("resp_lru", {load_lru, lru_in}, {1'b1, ~e.way});
                    check("resp_wr", {load_data, set_dirty, data_src}, {e.wr, e.wr, 1'b0});
                    check("resp_lat", cyc - e.start, e.lat);
                end
            end
            if (pmem_read) rd_cycles++;
            if (pmem_write) wr_cycles++;
            if (pmem_write && !pmem_addr_sel) bad++;
            if (pmem_read && pmem_addr_sel) bad++;
            if ((pmem_read || pmem_write) && way_sel != lru_m) bad++;
            if (pmem_read && pmem_resp) begin
                fills++;
                if ({load_data, load_tag, set_valid, clr_dirty, data_src} != 5'b11111) bad++;
            end
        end
    end

    int exp_hit = 0, exp_miss = 0;

    task automatic clear_stats();
        rd_cycles = 0; wr_cycles = 0; fills = 0; bad = 0;
    endtask

    task automatic do_req(input logic wr, input logic [7:0] tg);
        exp_t e;
        int   r0;
        logic h0, h1;
        h0 = vld[0] && tag[0] == tg;
        h1 = vld[1] && tag[1] == tg;
        e.wr = wr;
        e.start = cyc;
        if (h0 || h1) begin
            e.way = h0 ? 1'b0 : 1'b1;
            e.lat = 1;
            exp_hit++;
        end else begin
            e.way = lru_m;
            e.lat = drt[lru_m] ? 2 + 2 * PLAT : 2 + PLAT;
            exp_hit++;
            exp_miss++;
        end
        exp_q.push_back(e);
        r0 = resp_cnt;
        req_tag = tg;
        mem_read = ~wr;
        mem_write = wr;
        for (int i = 0; i < 100 && resp_cnt == r0; i++) @(posedge clk);
        if (resp_cnt == r0) check("resp_timeout", 0, 1);
        #1;
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        int r0;
        vld[0] = 0; vld[1] = 0; drt[0] = 0; drt[1] = 0;
        tag[0] = 0; tag[1] = 0; lru_m = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", {mem_resp, pmem_read, pmem_write, way_sel, load_data, load_tag,
              set_valid, set_dirty, clr_dirty, load_lru, lru_in, data_src, pmem_addr_sel}, 0);
        check("rst_counts", {hit_count, miss_count}, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // clean read miss into way 1, then read hit way 1
        clear_stats();
        do_req(1'b0, 8'hA1);
        check("clean_rd_cycles", rd_cycles, PLAT);
        check("clean_wr_cycles", wr_cycles, 0);
        check("clean_fills", fills, 1);
        check("clean_bad", bad, 0);
        check("clean_counts", {hit_count, miss_count}, {16'd1, 16'd1});
        clear_stats();
        do_req(1'b0, 8'hA1);
        check("hit_pmem", rd_cycles + wr_cycles, 0);
        check("hit_counts", {hit_count, miss_count}, {exp_hit[15:0], exp_miss[15:0]});

        // write miss into way 0, write hits on both ways
        do_req(1'b1, 8'hB2);
        do_req(1'b1, 8'hB2);
        do_req(1'b1, 8'hA1);

        // dirty write miss: writeback of B then fill of C
        clear_stats();
        do_req(1'b1, 8'hC3);
        check("dirty_wr_cycles", wr_cycles, PLAT);
        check("dirty_rd_cycles", rd_cycles, PLAT);
        check("dirty_bad", bad, 0);
        check("dirty_counts", {hit_count, miss_count}, {exp_hit[15:0], exp_miss[15:0]});

        // request dropped during writeback: line still filled, no response
        clear_stats();
        r0 = resp_cnt;
        req_tag = 8'hD4;
        mem_read = 1'b1;
        repeat (3) @(posedge clk);
        #1 mem_read = 1'b0;
        for (int i = 0; i < 40 && fills == 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        exp_miss++;
        check("drop_fills", fills, 1);
        check("drop_noresp", resp_cnt, r0);
        check("drop_line", {vld[1], tag[1]}, {1'b1, 8'hD4});
        check("drop_counts", {hit_count, miss_count}, {exp_hit[15:0], exp_miss[15:0]});

        // saturation, then clear racing a hit
        force dut.hit_count = 16'hFFFE;
        #1 release dut.hit_count;
        do_req(1'b0, 8'hD4);
        check("sat_reach", hit_count, 16'hFFFF);
        do_req(1'b0, 8'hD4);
        check("sat_hold", hit_count, 16'hFFFF);
        clr_counts = 1'b1;
        do_req(1'b0, 8'hD4);
        clr_counts = 1'b0;
        check("clr_vs_hit", {hit_count, miss_count}, 0);

        // asynchronous reset in the middle of an allocate
        r0 = resp_cnt;
        req_tag = 8'hE5;
        mem_read = 1'b1;
        for (int i = 0; i < 20 && !pmem_read; i++) @(posedge clk);
        check("alloc_started", pmem_read, 1);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("rst_mid_outputs", {mem_resp, pmem_read, pmem_write, way_sel, load_data, load_tag,
              set_valid, set_dirty, clr_dirty, load_lru, lru_in, data_src, pmem_addr_sel}, 0);
        check("rst_mid_counts", {hit_count, miss_count}, 0);
        mem_read = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_noresp", resp_cnt, r0);
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
